// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and loads
// the IF/ID register, with stall, redirect/squash and saturating perf counters.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_data,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nx;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_pc4;
    logic               r_valid;
    logic [CNT_W-1:0]   r_fetch_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_fetch;
    logic               w_squash;
    logic [31:0]        w_target;
    logic [31:0]        w_pc_inc;

    always_comb begin
        w_state_nx = r_state;
        w_fetch    = 1'b0;
        w_squash   = 1'b0;
        w_pc_inc   = r_pc + 32'd4;
        // jump wins over branch; targets are forced word-aligned
        w_target   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};

        if (jump || branch_taken) begin
            w_squash   = 1'b1;
            w_state_nx = RUN;
        end else begin
            unique case (r_state)
                BUBBLE: w_state_nx = stall ? BUBBLE : RUN;
                RUN: begin
                    if (stall) w_state_nx = HOLD;
                    else       w_fetch    = 1'b1;
                end
                HOLD: begin
                    if (!stall) begin
                        w_fetch    = 1'b1;
                        w_state_nx = RUN;
                    end
                end
                default: w_state_nx = BUBBLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= BUBBLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_pc4       <= '0;
            r_valid     <= 1'b0;
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_squash) begin
            r_pc    <= w_target;
            r_instr <= '0;
            r_valid <= 1'b0;
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else if (w_fetch) begin
            r_pc    <= w_pc_inc;
            r_instr <= rom_data;
            r_pc4   <= w_pc_inc;
            r_valid <= 1'b1;
            if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
        end
    end

    assign rom_addr    = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign fetch_cnt   = r_fetch_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed, table-driven bench for if_fetch_ctrl with a behavioural 64-word ROM;
// a second narrow-counter instance exercises counter saturation.
module tb_if_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] fcnt;
        logic [15:0] flcnt;
    } vec_t;

    vec_t vecs[$];

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] rom_addr, rom_data, if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [15:0] fetch_cnt, flush_cnt;

    logic        s_reset, s_stall, s_jump;
    logic [31:0] s_rom_addr, s_instr, s_pc4;
    logic [31:0] s_rom_data = 32'h0;
    logic [31:0] s_zero32   = 32'h0;
    logic        s_zero1    = 1'b0;
    logic        s_valid;
    logic [3:0]  s_fcnt, s_flcnt;

    logic [31:0] rom [64];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[7:2]];

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
        .clk(clk), .reset(s_reset), .stall(s_stall),
        .branch_taken(s_zero1), .branch_target(s_zero32),
        .jump(s_jump), .jump_target(s_zero32),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .if_id_instr(s_instr), .if_id_pc4(s_pc4), .if_id_valid(s_valid),
        .fetch_cnt(s_fcnt), .flush_cnt(s_flcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic st, input logic b, input logic [31:0] bta,
                       input logic j, input logic [31:0] jta,
                       input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                       input logic ev, input logic [15:0] ef, input logic [15:0] efl);
        vec_t v;
        v.rst = rs; v.stall = st; v.br = b; v.bt = bta; v.jmp = j; v.jt = jta;
        v.addr = ea; v.instr = ei; v.pc4 = ep; v.valid = ev; v.fcnt = ef; v.flcnt = efl;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1100_0000 | i;
        rom[0]  = 32'h2008_0020;
        rom[1]  = 32'h2009_0037;
        rom[13] = 32'hAC15_0008;

        //  rst st br bt             jmp jt             addr           instr          pc4            v  fcnt flcnt
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h00,        32'h0,         32'h00,        0, 0,  0); // bubble
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h04,        32'h2008_0020, 32'h04,        1, 1,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h08,        32'h2009_0037, 32'h08,        1, 2,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h0C,        32'h1100_0002, 32'h0C,        1, 3,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'h1100_0003, 32'h10,        1, 4,  0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        32'h1100_0003, 32'h10,        1, 4,  0); // stall x3
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        32'h1100_0003, 32'h10,        1, 4,  0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        32'h1100_0003, 32'h10,        1, 4,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h14,        32'h1100_0004, 32'h14,        1, 5,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h18,        32'h1100_0005, 32'h18,        1, 6,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h1C,        32'h1100_0006, 32'h1C,        1, 7,  0);
        add(0, 0, 1, 32'h37,        0, 32'h0,         32'h34,        32'h0,         32'h1C,        0, 7,  1); // branch
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h38,        32'hAC15_0008, 32'h38,        1, 8,  1);
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h38,        32'hAC15_0008, 32'h38,        1, 8,  1);
        add(0, 1, 1, 32'h20,        1, 32'h00,        32'h00,        32'h0,         32'h38,        0, 8,  2); // jump+branch+stall
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h04,        32'h2008_0020, 32'h04,        1, 9,  2);
        add(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,         32'h04,        0, 9,  3);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h00,        32'h1100_003F, 32'h00,        1, 10, 3); // wrap
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h04,        32'h2008_0020, 32'h04,        1, 11, 3);
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h04,        32'h2008_0020, 32'h04,        1, 11, 3);
        add(1, 1, 0, 32'h0,         1, 32'h80,        32'h00,        32'h0,         32'h00,        0, 0,  0); // reset in HOLD
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h00,        32'h0,         32'h00,        0, 0,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h00,        32'h0,         32'h00,        0, 0,  0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h04,        32'h2008_0020, 32'h04,        1, 1,  0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         32'h00,        32'h0,         32'h00,        0, 0,  0);
        add(0, 0, 0, 32'h0,         1, 32'h40,        32'h40,        32'h0,         32'h00,        0, 0,  1); // redirect in BUBBLE
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h44,        32'h1100_0010, 32'h44,        1, 1,  1);
        add(0, 0, 1, 32'h103,       0, 32'h0,         32'h100,       32'h0,         32'h44,        0, 1,  2);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h104,       32'h2008_0020, 32'h104,       1, 2,  2); // ROM index wrap

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        s_reset = 1'b1; s_stall = 1'b0; s_jump = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst addr",  rom_addr, 32'h0);
        chk("rst valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst instr", if_id_instr, 32'h0);
        chk("rst fcnt",  {16'b0, fetch_cnt}, 32'h0);
        chk("rst flcnt", {16'b0, flush_cnt}, 32'h0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; stall = vecs[i].stall;
            branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].jmp; jump_target = vecs[i].jt;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d addr", i),  rom_addr, vecs[i].addr);
            chk($sformatf("v%0d instr", i), if_id_instr, vecs[i].instr);
            chk($sformatf("v%0d pc4", i),   if_id_pc4, vecs[i].pc4);
            chk($sformatf("v%0d valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d fcnt", i),  {16'b0, fetch_cnt}, {16'b0, vecs[i].fcnt});
            chk($sformatf("v%0d flcnt", i), {16'b0, flush_cnt}, {16'b0, vecs[i].flcnt});
        end

        // saturation: 4-bit counters on the second instance
        s_reset = 1'b0;
        @(posedge clk); // bubble
        repeat (15) @(posedge clk);
        #1;
        chk("sat fcnt at 15", {28'b0, s_fcnt}, 32'hF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat fcnt held", {28'b0, s_fcnt}, 32'hF);
        chk("sat valid", {31'b0, s_valid}, 32'h1);
        s_jump = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        chk("sat flcnt held", {28'b0, s_flcnt}, 32'hF);
        chk("sat fcnt after flush", {28'b0, s_fcnt}, 32'hF);
        s_jump = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
